// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults and controller state type for the banked SRAM array
package sram_pkg;
    localparam int NBANK_DEF = 8;
    localparam int DEPTH_DEF = 128;
    localparam int WIDTH_DEF = 128;
    typedef enum logic {INIT, READY} state_e;
endpackage

// File: rtl/sram_bank.sv
// sram_bank: one storage bank with a bit-masked primary port and a forwarding secondary read port
module sram_bank
    import sram_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int AW      = $clog2(DEPTH),
    parameter int DUAL_RD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ready_i,
    input  logic [AW-1:0]    init_addr_i,
    input  logic             cen_n,
    input  logic             wen_n,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] bwen_n,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic             nxt_ren,
    input  logic [AW-1:0]    nxt_addr,
    output logic [WIDTH-1:0] nxt_rdata
);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pri_ok, acc, wr;
    logic [WIDTH-1:0] rd_word, merged, rdata_q, rdata_d;

    assign pri_ok  = {1'b0, addr} < LIM;
    assign acc     = ready_i & ~cen_n;
    assign wr      = acc & ~wen_n & pri_ok;
    assign rd_word = pri_ok ? mem_q[addr] : '0;
    assign merged  = (wdata & ~bwen_n) | (rd_word & bwen_n);
    assign rdata_d = acc ? (~wen_n ? (pri_ok ? merged : '0) : rd_word) : rdata_q;
    assign rdata   = rdata_q;

    // storage has no reset: the controller sweeps zeros through it while not ready
    always_ff @(posedge clk) begin
        if (!ready_i) mem_q[init_addr_i] <= '0;
        else if (wr) mem_q[addr] <= merged;
    end

    // primary read register, write-first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end

    if (DUAL_RD != 0) begin : g_nxt
        logic             nxt_ok, fwd;
        logic [WIDTH-1:0] nxt_q, nxt_d;
        assign nxt_ok    = {1'b0, nxt_addr} < LIM;
        assign fwd       = wr && (nxt_addr == addr);
        assign nxt_d     = (ready_i & nxt_ren) ? (fwd ? merged : (nxt_ok ? mem_q[nxt_addr] : '0)) : nxt_q;
        assign nxt_rdata = nxt_q;
        // secondary read register, forwarding a same-cycle primary write
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) nxt_q <= '0;
            else nxt_q <= nxt_d;
        end
    end else begin : g_nxt_off
        assign nxt_rdata = '0;
    end
endmodule

// File: rtl/sram_bank_array.sv
// sram_bank_array: NBANK independent SRAM banks behind a zero-fill init/flush controller
module sram_bank_array
    import sram_pkg::*;
#(
    parameter int NBANK   = NBANK_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int AW      = $clog2(DEPTH),
    parameter int DUAL_RD = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    output logic                   ready_o,
    input  logic [NBANK-1:0]       cen_n,
    input  logic [NBANK-1:0]       wen_n,
    input  logic [NBANK*AW-1:0]    addr,
    input  logic [NBANK*WIDTH-1:0] bwen_n,
    input  logic [NBANK*WIDTH-1:0] wdata,
    output logic [NBANK*WIDTH-1:0] rdata,
    input  logic [NBANK-1:0]       nxt_ren,
    input  logic [NBANK*AW-1:0]    nxt_addr,
    output logic [NBANK*WIDTH-1:0] nxt_rdata
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    assign ready_o = state_q == READY;

    // state and sweep counter; reset aborts any sweep in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // sweep every address once, restarting on flush; flush in READY re-enters the sweep
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            state_d = (!flush_i && cnt_q == LAST) ? READY : INIT;
            cnt_d   = (flush_i || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end else if (flush_i) begin
            state_d = INIT;
            cnt_d   = '0;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        sram_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .DUAL_RD(DUAL_RD)) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .ready_i     (ready_o),
            .init_addr_i (cnt_q),
            .cen_n       (cen_n[b]),
            .wen_n       (wen_n[b]),
            .addr        (addr[b*AW +: AW]),
            .bwen_n      (bwen_n[b*WIDTH +: WIDTH]),
            .wdata       (wdata[b*WIDTH +: WIDTH]),
            .rdata       (rdata[b*WIDTH +: WIDTH]),
            .nxt_ren     (nxt_ren[b]),
            .nxt_addr    (nxt_addr[b*AW +: AW]),
            .nxt_rdata   (nxt_rdata[b*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_sram_bank_array.sv
// tb_sram_bank_array: scoreboard bench comparing the bank array against an array-based memory model
module tb_sram_bank_array;
    localparam int NBANK = 8;
    localparam int DEPTH = 128;
    localparam int WIDTH = 128;
    localparam int AW    = 7;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush, ready;
    logic [NBANK-1:0]       cen_n, wen_n, nxt_ren;
    logic [NBANK*AW-1:0]    addr, nxt_addr;
    logic [NBANK*WIDTH-1:0] bwen_n, wdata, rdata, nxt_rdata;

    sram_bank_array dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .ready_o(ready),
        .cen_n(cen_n), .wen_n(wen_n), .addr(addr), .bwen_n(bwen_n), .wdata(wdata),
        .rdata(rdata), .nxt_ren(nxt_ren), .nxt_addr(nxt_addr), .nxt_rdata(nxt_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                     due;
        logic                   rdy;
        logic [NBANK*WIDTH-1:0] rd;
        logic [NBANK*WIDTH-1:0] nx;
    } exp_t;

    exp_t             sq[$];
    exp_t             mon_e;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] mm [NBANK][DEPTH];
    logic [WIDTH-1:0] er [NBANK];
    logic [WIDTH-1:0] en [NBANK];
    bit               rdy_m;
    int               left;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int b, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s bank %0d at cycle %0d: got %h expected %h", nm, b, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: compare every due expectation against the registered outputs
    always @(negedge clk) begin
        if (rst_n) begin
            while (sq.size() > 0 && sq[0].due <= cyc) begin
                mon_e = sq.pop_front();
                chk("ready_o", 0, WIDTH'(ready), WIDTH'(mon_e.rdy));
                for (int b = 0; b < NBANK; b++) begin
                    chk("rdata", b, rdata[b*WIDTH +: WIDTH], mon_e.rd[b*WIDTH +: WIDTH]);
                    chk("nxt_rdata", b, nxt_rdata[b*WIDTH +: WIDTH], mon_e.nx[b*WIDTH +: WIDTH]);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle();
        flush = 1'b0; cen_n = '1; wen_n = '1; nxt_ren = '0;
        addr = '0; nxt_addr = '0; bwen_n = '1; wdata = '0;
    endtask

    task automatic set_pri(input int b, input bit wr, input int a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] be);
        cen_n[b] = 1'b0;
        wen_n[b] = !wr;
        addr[b*AW +: AW] = AW'(a);
        wdata[b*WIDTH +: WIDTH] = d;
        bwen_n[b*WIDTH +: WIDTH] = be;
    endtask

    task automatic set_nxt(input int b, input int a);
        nxt_ren[b] = 1'b1;
        nxt_addr[b*AW +: AW] = AW'(a);
    endtask

    task automatic rand_acc();
        int a;
        for (int b = 0; b < NBANK; b++) begin
            a = $urandom_range(0, 15);
            cen_n[b] = 1'($urandom_range(0, 1));
            wen_n[b] = 1'($urandom_range(0, 1));
            addr[b*AW +: AW] = AW'(a);
            bwen_n[b*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? '0 : r128();
            wdata[b*WIDTH +: WIDTH] = r128();
            nxt_ren[b] = 1'($urandom_range(0, 1));
            nxt_addr[b*AW +: AW] = AW'(($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 15));
        end
    endtask

    task automatic model_reset();
        rdy_m = 1'b0;
        left = DEPTH;
        for (int b = 0; b < NBANK; b++) begin
            er[b] = '0;
            en[b] = '0;
        end
    endtask

    // one clock of the reference: memory semantics, then the ready/clear schedule
    task automatic step();
        exp_t             e;
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] be;
        if (rdy_m) begin
            for (int b = 0; b < NBANK; b++) begin
                if (!cen_n[b]) begin
                    a = addr[b*AW +: AW];
                    be = bwen_n[b*WIDTH +: WIDTH];
                    if (!wen_n[b]) mm[b][a] = (wdata[b*WIDTH +: WIDTH] & ~be) | (mm[b][a] & be);
                    er[b] = mm[b][a];
                end
            end
            for (int b = 0; b < NBANK; b++)
                if (nxt_ren[b]) en[b] = mm[b][nxt_addr[b*AW +: AW]];
            if (flush) begin
                rdy_m = 1'b0;
                left = DEPTH;
            end
        end else if (flush) begin
            left = DEPTH;
        end else begin
            left--;
            if (left == 0) begin
                rdy_m = 1'b1;
                for (int b = 0; b < NBANK; b++)
                    for (int i = 0; i < DEPTH; i++) mm[b][i] = '0;
            end
        end
        e.due = cyc + 1;
        e.rdy = rdy_m;
        for (int b = 0; b < NBANK; b++) begin
            e.rd[b*WIDTH +: WIDTH] = er[b];
            e.nx[b*WIDTH +: WIDTH] = en[b];
        end
        sq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit acc, output int n);
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            if (acc) rand_acc(); else idle();
            step();
            n++;
        end
        idle();
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, " ready_o"}, 0, WIDTH'(ready), '0);
        for (int b = 0; b < NBANK; b++) begin
            chk({nm, " rdata"}, b, rdata[b*WIDTH +: WIDTH], '0);
            chk({nm, " nxt_rdata"}, b, nxt_rdata[b*WIDTH +: WIDTH], '0);
        end
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] ones, half;
        ones = '1;
        half = {{64{1'b1}}, {64{1'b0}}};
        idle();
        model_reset();
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(1'b1, n);
        chk_int("initial sweep length", n, DEPTH);

        set_pri(3, 0, 'h45, '0, '1); step(); idle();
        chk("fresh read b3 0x45", 3, rdata[3*WIDTH +: WIDTH], '0);

        set_pri(0, 1, 'h10, ones, '0); step(); idle();
        set_pri(0, 0, 'h10, '0, '1); step(); idle();
        chk("full write b0", 0, rdata[0 +: WIDTH], ones);
        set_pri(0, 1, 'h10, '0, half); step(); idle();
        set_pri(0, 0, 'h10, '0, '1); step(); idle();
        chk("masked write b0", 0, rdata[0 +: WIDTH], half);

        set_pri(5, 1, 7, {16{8'hA5}}, '0); set_nxt(5, 7); step(); idle();
        chk("forward b5", 5, nxt_rdata[5*WIDTH +: WIDTH], {16{8'hA5}});

        repeat (400) begin
            rand_acc();
            step();
        end
        idle();

        set_pri(2, 1, 3, ones, '0); set_nxt(2, 3); flush = 1'b1; step(); idle();
        chk("access on flush cycle", 2, rdata[2*WIDTH +: WIDTH], ones);
        wait_ready(1'b0, n);
        chk_int("flush sweep length", n, DEPTH);
        set_pri(0, 0, 'h10, '0, '1); set_nxt(2, 3); step(); idle();
        chk("after flush b0", 0, rdata[0 +: WIDTH], '0);
        chk("after flush b2 nxt", 2, nxt_rdata[2*WIDTH +: WIDTH], '0);

        flush = 1'b1; step(); idle();
        repeat (60) begin
            rand_acc();
            step();
        end
        idle(); flush = 1'b1; step(); idle();
        wait_ready(1'b1, n);
        chk_int("low time with restart", 61 + n, 61 + DEPTH);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < NBANK; b++) begin
                set_pri(b, 0, a, '0, '1);
                set_nxt(b, 15 - a);
            end
            step(); idle();
        end

        set_pri(1, 1, 2, ones, '0); step(); idle();
        flush = 1'b1; step(); idle();
        repeat (30) step();
        chk("held during sweep", 1, rdata[1*WIDTH +: WIDTH], ones);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid-sweep reset");
        sq.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(1'b0, n);
        chk_int("sweep after reset", n, DEPTH);
        set_pri(1, 0, 2, '0, '1); step(); idle();
        chk("cleared after reset", 1, rdata[1*WIDTH +: WIDTH], '0);

        repeat (150) begin
            rand_acc();
            step();
        end
        idle();
        step();
        repeat (2) @(posedge clk);
        chk_int("scoreboard drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
